// File: rtl/commit_trace_checker.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_checker
// Purpose  : Compares the processor's per-instruction commit stream against
//            golden records pulled over a valid/ready interface. Commits are
//            buffered in a small FIFO. Each FIFO head is compared
//            field-by-field with the next golden record. The module reports
//            pass/fail, the retired count and the index and cause of the
//            first divergence.
// Ports    : clk, rst (async, active-high)
//            commit_valid/commit_rec : commit stream input (71-bit record)
//            gold_valid/gold_rec     : golden record stream input
//            gold_ready              : golden record consumed this cycle
//            done, fail              : sticky pass (halt matched) / fail flags
//            inst_count              : records compared and matched
//            fail_inum, fail_mask    : index and cause bits of first failure
// Record   : [70] halt [69] memRead [68] memWrite [67] regWrite
//            [66:64] writeReg [63:48] PC [47:32] writeData
//            [31:16] memAddr [15:0] memData
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [70:0]      commit_rec,
    input  logic             gold_valid,
    input  logic [70:0]      gold_rec,
    output logic             gold_ready,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] fail_inum,
    output logic [6:0]       fail_mask
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_DONE = 2'd1;
    localparam logic [1:0] c_ST_FAIL = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;

    logic [70:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;

    logic [CNT_W-1:0]   r_instCount;
    logic [CNT_W-1:0]   r_failInum;
    logic [6:0]         r_failMask;
    logic               r_done;
    logic               r_fail;

    logic               w_run;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_overflow;
    logic               w_mismatch;
    logic               w_failNow;
    logic               w_match;
    logic [70:0]        w_head;
    logic [5:0]         w_diff;

    assign w_run   = (r_state == c_ST_RUN);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_head  = r_mem[r_rdPtr];

    assign gold_ready = w_run && !w_empty;
    assign w_pop      = gold_ready && gold_valid;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_overflow = w_run && commit_valid && w_full && !w_pop;
    assign w_push     = w_run && commit_valid && !w_overflow;

    // Field comparison; payload fields only count when the golden flags say
    // the processor was supposed to produce them.
    always_comb begin
        w_diff = 6'b0;
        if (w_pop) begin
            w_diff[0] = (w_head[63:48] != gold_rec[63:48]);
            w_diff[1] = (w_head[70:67] != gold_rec[70:67]);
            w_diff[2] = gold_rec[67] && (w_head[66:64] != gold_rec[66:64]);
            w_diff[3] = gold_rec[67] && (w_head[47:32] != gold_rec[47:32]);
            w_diff[4] = (gold_rec[69] || gold_rec[68]) && (w_head[31:16] != gold_rec[31:16]);
            w_diff[5] = gold_rec[68] && (w_head[15:0] != gold_rec[15:0]);
        end
    end

    assign w_mismatch = (w_diff != 6'b0);
    assign w_failNow  = w_overflow || w_mismatch;
    assign w_match    = w_pop && !w_mismatch;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_run) begin
            if (w_failNow) begin
                w_stateNext = c_ST_FAIL;
            end else if (w_match && gold_rec[70]) begin
                w_stateNext = c_ST_DONE;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= commit_rec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            // Pointer widths equal log2(DEPTH), so wrap is the natural rollover.
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instCount <= '0;
            r_failInum  <= '0;
            r_failMask  <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
        end else if (w_run) begin
            if (w_failNow) begin
                r_fail     <= 1'b1;
                r_failMask <= {w_overflow, w_diff};
                r_failInum <= r_instCount;
            end else if (w_match) begin
                r_instCount <= r_instCount + CNT_W'(1);
                if (gold_rec[70]) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done       = r_done;
    assign fail       = r_fail;
    assign inst_count = r_instCount;
    assign fail_inum  = r_failInum;
    assign fail_mask  = r_failMask;

endmodule
`default_nettype wire

// File: doc/commit_trace_checker.md
Name: commit_trace_checker

Overview:
- Hardware-side consumer of the processor's per-instruction commit stream: PC, register write, memory access and halt.
- Each commit is buffered in a small FIFO, then compared field-by-field against golden records pulled over a valid/ready interface.
- Reports pass/fail, the retired-instruction count and the index and fields of the first divergence.
- Sits beside the processor in simulation and FPGA self-check builds. It replaces text-trace diffing with an in-circuit comparison.

Parameters:
- DEPTH, 4: commit FIFO entries. Power of two, ≥2.
- CNT_W, 32: width of inst_count and fail_inum.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- commit_valid  in  1  one instruction committed this cycle
- commit_rec  in  71  packed commit record, layout R below
- gold_valid  in  1  golden record available
- gold_rec  in  71  golden record, layout R
- gold_ready  out  1  golden record consumed this cycle
- done  out  1  halt committed with all records matching (sticky)
- fail  out  1  mismatch or overflow detected (sticky)
- inst_count  out  CNT_W  number of records compared and matched
- fail_inum  out  CNT_W  index (0-based) of the first failing record
- fail_mask  out  7  cause bits, see below

Behaviour:
- Layout R:
  - [70] halt, [69] memRead, [68] memWrite, [67] regWrite
  - [66:64] writeReg, [63:48] PC, [47:32] writeData
  - [31:16] memAddr, [15:0] memData
- Reset (async, rst=1) clears FIFO pointers and counters. All outputs go to 0 and the state goes to RUN.
- States:
  - RUN: accepting and comparing records.
  - DONE, FAIL: absorbing until rst.
- FIFO push: in RUN, when commit_valid=1, commit_rec is pushed.
  - Push while full with no pop in the same cycle → FAIL, fail_mask[6]=1 (overflow), fail_inum=inst_count.
  - Push and pop in the same cycle while full is legal. Occupancy stays DEPTH.
  - Pointers wrap modulo DEPTH.
- Pop/compare:
  - In RUN, gold_ready = (FIFO non-empty), combinationally.
  - When gold_valid && gold_ready, the FIFO head and gold_rec are compared that cycle. The head is popped and the result takes effect at the next posedge (1-cycle latency).
- Compare fields (mask bit → condition):
  - bit0: PC differs.
  - bit1: any of {halt, memRead, memWrite, regWrite} differs.
  - bit2: writeReg differs, and golden regWrite=1.
  - bit3: writeData differs, and golden regWrite=1.
  - bit4: memAddr differs, and golden memRead|memWrite=1.
  - bit5: memData differs, and golden memWrite=1.
- On a match: inst_count increments, wrapping at 2^CNT_W. If golden halt=1, go to DONE, set done=1, and keep inst_count including the halt record.
- On a mismatch: go to FAIL, set fail=1, load fail_mask with the differing bits and set fail_inum=inst_count. inst_count is not incremented.
- Overflow and mismatch in the same cycle: go to FAIL, OR both causes into fail_mask, fail_inum=inst_count.
- In DONE and FAIL:
  - gold_ready=0; commits are ignored (no push, no overflow).
  - All outputs hold until rst.
- Fields not required by golden flags are don't-care and never cause failure.
- rst asserted mid-operation discards FIFO contents and counts immediately. The first record after rst deassertion is inum 0.

Test Plan:
- Three matching records: {PC 0x0000, regWrite r1=0x0005}, {PC 0x0002, memWrite addr 0x0010 data 0x0005}, {PC 0x0004, halt}. Golden always valid → done=1 one cycle after the halt compare, inst_count=3, fail=0.
- Record 1 golden writeData=0x0006, commit 0x0005 → fail=1, fail_inum=1, fail_mask=7'b0001000, gold_ready=0 thereafter.
- Golden regWrite=0 and memWrite=0, with commit writeData/memAddr garbage but PC and flags equal → match, inst_count increments.
- gold_valid held 0; commit_valid=1 for DEPTH+1 consecutive cycles → fail=1, fail_mask[6]=1, fail_inum=0.
- FIFO full, then commit_valid and gold pop in the same cycle for 10 cycles → no overflow; inst_count advances by 10.
- rst pulsed asynchronously mid-stream with 2 records buffered → all outputs 0 immediately. A fresh 1-record halt stream then gives done=1, inst_count=1.
